regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the pipeline's 32x32 register file, for the MIPS pipeline ID/WB stages.
- Provides two combinational read ports and one clocked write port.
- Optional write-to-read bypass; register 0 can be hardwired to zero.
- Integrated busy-bit scoreboard: tracks registers with in-flight writes and raises a hazard/stall to the issue logic in ID.

Parameters:
- DATA_W, 32, width of each register and data port.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W (localparam, not overridable).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports and counted when resolving hazards; 0 = no forwarding.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never goes busy.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Addr_A  in  ADDR_W  read address, port A.
- Addr_B  in  ADDR_W  read address, port B.
- Port_A  out  DATA_W  read data, port A.
- Port_B  out  DATA_W  read data, port B.
- wr  in  1  writeback enable.
- Addr_Wr  in  ADDR_W  writeback address.
- Din  in  DATA_W  writeback data.
- iss_valid  in  1  ID stage presents an instruction for issue.
- iss_use_A  in  1  instruction reads Addr_A.
- iss_use_B  in  1  instruction reads Addr_B.
- iss_wr  in  1  instruction will write a register.
- iss_dest  in  ADDR_W  destination register of the issuing instruction.
- hazard  out  1  stall: instruction must not issue this cycle.
- busy_vec  out  DEPTH  per-register busy bits, for debug and verification.

Behaviour:
- Reset (rst_n low, asynchronous): all DEPTH registers = 0; busy_vec = 0.
  - hazard is combinational, so with iss_valid low it reads 0 immediately.
  - Reset asserted mid-operation discards all pending state; no write lands on the edge where rst_n is low.
- Read: combinational, zero latency.
  - Port_X = (ZERO_REG && Addr_X==0) ? 0 : (BYPASS && wr && Addr_Wr==Addr_X && !(ZERO_REG && Addr_X==0)) ? Din : reg[Addr_X].
  - With BYPASS=0, a same-cycle write is visible on the next cycle only.
- Write: on posedge clk, if wr and !(ZERO_REG && Addr_Wr==0), reg[Addr_Wr] <= Din.
- Issue acceptance: issue_ok = iss_valid && !hazard.
- Scoreboard update, per register r, on posedge clk:
  - set_r = issue_ok && iss_wr && iss_dest==r && !(ZERO_REG && r==0).
  - clr_r = wr && Addr_Wr==r.
  - busy[r] <= set_r ? 1 : clr_r ? 0 : busy[r]. Set wins over a simultaneous clear, because the new producer supersedes the old one.
- Hazard:
  - ready_X = !busy[Addr_X] || (BYPASS && wr && Addr_Wr==Addr_X) || (ZERO_REG && Addr_X==0).
  - waw = iss_wr && busy[iss_dest] && !(wr && Addr_Wr==iss_dest).
  - hazard = iss_valid && ((iss_use_A && !ready_A) || (iss_use_B && !ready_B) || waw).
  - Purely combinational; no state machine beyond the busy bits.
- Single outstanding producer per register is enforced by the waw term.
- A writeback to a non-busy register is legal (e.g. preloaded values): data is written, busy stays 0.
- Addr_A==Addr_B is legal; both ports return identical data.
- wr to register 0 with ZERO_REG=1: no effect on data or busy.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W constants;
  - the zero-register index constant;
  - a function is_zero_reg(addr, ZERO_REG).
- Sub-module regfile_scoreboard (params ADDR_W, ZERO_REG, BYPASS):
  - owns busy_vec and the hazard/ready logic;
  - inputs: iss_* signals, wr, Addr_Wr, Addr_A, Addr_B;
  - outputs: hazard, busy_vec.
- Top regfile_sb holds the storage array and the read/bypass muxes.

Test Plan:
- Reset then write: pulse rst_n low, write 0xDEADBEEF to r5, read Addr_A=5 next cycle -> Port_A=0xDEADBEEF; before the write, all reads = 0.
- Bypass: BYPASS=1, wr=1, Addr_Wr=7, Din=0x1234, Addr_B=7 in the same cycle -> Port_B=0x1234 that cycle. With BYPASS=0 -> old value that cycle, 0x1234 the next.
- Zero register: write 0xFFFFFFFF to r0 and issue with iss_dest=0 -> Port_A(Addr_A=0)=0, busy_vec[0]=0.
- RAW stall: issue iss_dest=3 (accepted, busy[3]=1); next cycle issue with Addr_A=3, iss_use_A=1 -> hazard=1 until the cycle wr=1 with Addr_Wr=3 (BYPASS=1: hazard=0 that cycle), then busy[3]=0.
- WAW plus simultaneous set/clear:
  - busy[4]=1 and issue iss_dest=4 without writeback -> hazard=1.
  - Same issue coinciding with wr to r4 -> hazard=0, and busy[4] stays 1 after the edge.
- Async reset mid-operation: busy[3]=busy[9]=1, drop rst_n between clock edges -> busy_vec=0 and Port_A=0 immediately, before the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with busy-bit scoreboard.
// Imported by the storage top and the scoreboard sub-module.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    localparam logic [31:0] ZERO_IDX = 32'd0;

    // True when addr names the hardwired-zero register and that feature is enabled.
    function automatic logic is_zero_reg(input logic [31:0] addr, input bit zero_reg);
        return zero_reg && (addr == ZERO_IDX);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register marks an in-flight producer.
// Raises hazard for RAW on either read port and for WAW on the destination.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic              iss_use_A,
    input  logic              iss_use_B,
    input  logic              iss_wr,
    input  logic [ADDR_W-1:0] iss_dest,
    input  logic              wr,
    input  logic [ADDR_W-1:0] Addr_Wr,
    input  logic [ADDR_W-1:0] Addr_A,
    input  logic [ADDR_W-1:0] Addr_B,
    output logic              hazard,
    output logic [DEPTH-1:0]  busy_vec
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             ready_a;
    logic             ready_b;
    logic             waw;
    logic             issue_ok;

    // A writeback landing this cycle resolves the dependency only when it is forwarded.
    assign ready_a = !busy_q[Addr_A] || (BYPASS && wr && (Addr_Wr == Addr_A)) ||
                     is_zero_reg(32'(Addr_A), ZERO_REG);
    assign ready_b = !busy_q[Addr_B] || (BYPASS && wr && (Addr_Wr == Addr_B)) ||
                     is_zero_reg(32'(Addr_B), ZERO_REG);

    assign waw      = iss_wr && busy_q[iss_dest] && !(wr && (Addr_Wr == iss_dest));
    assign hazard   = iss_valid && ((iss_use_A && !ready_a) || (iss_use_B && !ready_b) || waw);
    assign issue_ok = iss_valid && !hazard;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (wr)
            busy_d[Addr_Wr] = 1'b0;
        if (issue_ok && iss_wr && !is_zero_reg(32'(iss_dest), ZERO_REG))
            busy_d[iss_dest] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read forwarding and an integrated issue scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int DEPTH   = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Addr_A,
    input  logic [ADDR_W-1:0] Addr_B,
    output logic [DATA_W-1:0] Port_A,
    output logic [DATA_W-1:0] Port_B,
    input  logic              wr,
    input  logic [ADDR_W-1:0] Addr_Wr,
    input  logic [DATA_W-1:0] Din,
    input  logic              iss_valid,
    input  logic              iss_use_A,
    input  logic              iss_use_B,
    input  logic              iss_wr,
    input  logic [ADDR_W-1:0] iss_dest,
    output logic              hazard,
    output logic [DEPTH-1:0]  busy_vec
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr && !is_zero_reg(32'(Addr_Wr), ZERO_REG)) begin
            mem[Addr_Wr] <= Din;
        end
    end

    // Zero register takes priority so a write to r0 is never forwarded.
    assign Port_A = is_zero_reg(32'(Addr_A), ZERO_REG)      ? '0  :
                    (BYPASS && wr && (Addr_Wr == Addr_A))   ? Din : mem[Addr_A];
    assign Port_B = is_zero_reg(32'(Addr_B), ZERO_REG)      ? '0  :
                    (BYPASS && wr && (Addr_Wr == Addr_B))   ? Din : mem[Addr_B];

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_use_A (iss_use_A),
        .iss_use_B (iss_use_B),
        .iss_wr    (iss_wr),
        .iss_dest  (iss_dest),
        .wr        (wr),
        .Addr_Wr   (Addr_Wr),
        .Addr_A    (Addr_A),
        .Addr_B    (Addr_B),
        .hazard    (hazard),
        .busy_vec  (busy_vec)
    );

endmodule
